// File: rtl/mux_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_tree_pkg
// Brief    : Shared types, widths and the round-robin pick helper.
// Revision : 1.0
// ============================================================================
package mux_tree_pkg;

    localparam int SEL_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set bit scanning upward from ptr, wrapping at n.
    function automatic pick_t rr_pick(input logic [15:0] req,
                                      input logic [SEL_W-1:0] ptr,
                                      input int n);
        pick_t res;
        int    pos;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            pos = int'(ptr) + i;
            if (pos >= n) pos = pos - n;
            if (i < n && !res.found && req[pos[3:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[SEL_W-1:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_tree_sched_slice.sv
`default_nettype none
// ============================================================================
// Module   : mux16_slice
// Brief    : One bit of the 16:1 tree: four 4:1 LUTs, two F7 and one F8 mux.
// Revision : 1.0
// ============================================================================
module mux16_slice #(
    parameter int N_REQ = 16
) (
    input  logic [N_REQ-1:0] d,
    input  logic [3:0]       s,
    output logic             y
);

    logic [15:0] d_pad;
    logic [3:0]  lut_o;
    logic [1:0]  f7_o;

    // Codes at or above N_REQ never select, but the tree still sees zeros.
    always_comb begin
        d_pad           = '0;
        d_pad[N_REQ-1:0] = d;
    end

    for (genvar i = 0; i < 4; i++) begin : g_lut
        logic [3:0] grp;
        assign grp      = d_pad[4*i +: 4];
        assign lut_o[i] = grp[s[1:0]];
    end

    assign f7_o[0] = s[2] ? lut_o[1] : lut_o[0];
    assign f7_o[1] = s[2] ? lut_o[3] : lut_o[2];
    assign y       = s[3] ? f7_o[1]  : f7_o[0];

endmodule
`default_nettype wire

// File: rtl/mux_tree_sched.sv
`default_nettype none
// ============================================================================
// Module   : mux_tree_sched
// Brief    : Round-robin packet/burst scheduler driving a 16:1 mux-tree datapath.
// Revision : 1.0
// ============================================================================
module mux_tree_sched
    import mux_tree_pkg::*;
#(
    parameter int N_REQ     = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                      C,
    input  logic                      R,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          last,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    output logic [N_REQ-1:0]          ack,
    output logic [SEL_W-1:0]          sel,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_last,
    input  logic                      o_ready
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic [15:0]      req_pad;
    logic [15:0]      last_pad;
    logic [15:0]      ack_pad;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] ptr_nxt;
    logic             xfer;
    logic             release_now;
    logic             last_mux;
    pick_t            pick;

    always_comb begin
        req_pad             = '0;
        last_pad            = '0;
        req_pad[N_REQ-1:0]  = req;
        last_pad[N_REQ-1:0] = last;
    end

    assign pick = rr_pick(req_pad, ptr, N_REQ);

    // Reset suppresses the beat in the cycle it is asserted.
    always_comb begin
        o_valid      = (state == ST_GRANT) && !R && req_pad[sel];
        xfer         = o_valid && o_ready;
        ack_pad      = '0;
        ack_pad[sel] = xfer;
    end
    assign ack = ack_pad[N_REQ-1:0];

    assign cnt_nxt     = cnt + 1'b1;
    assign ptr_nxt     = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
    assign release_now = !req_pad[sel] ||
                         (xfer && (last_pad[sel] || cnt_nxt == CNT_W'(MAX_BURST)));

    always_ff @(posedge C) begin
        if (R) begin
            state <= ST_IDLE;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick.found) begin
                        sel   <= pick.idx;
                        cnt   <= '0;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer) cnt <= cnt_nxt;
                    if (release_now) begin
                        ptr   <= ptr_nxt;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        logic [N_REQ-1:0] col;
        always_comb begin
            for (int k = 0; k < N_REQ; k++) col[k] = data_i[k*DATA_W + b];
        end
        mux16_slice #(.N_REQ(N_REQ)) u_slice (
            .d (col),
            .s (sel),
            .y (o_data[b])
        );
    end

    mux16_slice #(.N_REQ(N_REQ)) u_last_slice (
        .d (last),
        .s (sel),
        .y (last_mux)
    );

    assign o_last = o_valid && last_mux;

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_tree_sched
// Brief    : Directed self-checking bench for the round-robin mux-tree scheduler.
// Revision : 1.0
// ============================================================================
module tb_mux_tree_sched;

    logic         C;
    logic         R;
    logic [15:0]  req;
    logic [15:0]  last;
    logic [127:0] data_i;
    logic [15:0]  ack;
    logic [3:0]   sel;
    logic         o_valid;
    logic [7:0]   o_data;
    logic         o_last;
    logic         o_ready;

    int n_assert;
    int n_fail;

    mux_tree_sched #(.N_REQ(16), .DATA_W(8), .MAX_BURST(8)) dut (
        .C       (C),
        .R       (R),
        .req     (req),
        .last    (last),
        .data_i  (data_i),
        .ack     (ack),
        .sel     (sel),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_ready (o_ready)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        data_i[k*8 +: 8] = v;
    endtask

    int b5;
    int b9;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        R = 1'b1; req = '0; last = '0; data_i = '0; o_ready = 1'b1;
        tick(); tick();
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        R = 1'b0;

        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_valid", 32'(o_valid), 32'd0);
            chk("idle_ack", 32'(ack), 32'd0);
            chk("idle_sel", 32'(sel), 32'd0);
            tick();
        end

        // Single 3-beat packet from requester 3
        req = 16'h0008; set_data(3, 8'h31);
        #1 chk("p3_arb_valid", 32'(o_valid), 32'd0);
        tick();
        for (int j = 1; j <= 3; j++) begin
            set_data(3, 8'(8'h30 + j));
            last[3] = (j == 3);
            #1;
            chk("p3_sel", 32'(sel), 32'd3);
            chk("p3_ack", 32'(ack), 32'h0008);
            chk("p3_data", 32'(o_data), 32'(8'h30 + j));
            chk("p3_last", 32'(o_last), 32'(j == 3));
            tick();
        end
        req = '0; last = '0;
        #1;
        chk("p3_rel_valid", 32'(o_valid), 32'd0);
        chk("p3_rel_ack", 32'(ack), 32'd0);
        tick();
        // ptr must now be 4: with 3 and 5 requesting, 5 wins
        req = 16'h0028;
        #1 chk("ptr4_idle_valid", 32'(o_valid), 32'd0);
        tick();
        #1;
        chk("ptr4_sel", 32'(sel), 32'd5);
        chk("ptr4_valid", 32'(o_valid), 32'd1);
        req = '0;
        tick();
        R = 1'b1; tick(); R = 1'b0;

        // All requesters, 1-beat packets
        req = 16'hFFFF; last = 16'hFFFF;
        for (int k = 0; k < 16; k++) set_data(k, 8'(8'hA0 | k));
        for (int g = 0; g <= 16; g++) begin
            #1;
            chk("rr_bubble_valid", 32'(o_valid), 32'd0);
            chk("rr_bubble_ack", 32'(ack), 32'd0);
            tick();
            #1;
            chk("rr_sel", 32'(sel), 32'(g % 16));
            chk("rr_ack", 32'(ack), 32'(16'h1 << (g % 16)));
            chk("rr_data", 32'(o_data), 32'(8'hA0 | (g % 16)));
            tick();
        end
        req = '0; last = '0;
        R = 1'b1; tick(); R = 1'b0;

        // Burst limit: 5 (20-beat packet) vs 9 (2-beat packet)
        b5 = 0; b9 = 0;
        req = 16'h0220;
        #1 chk("bst_idle0", 32'(o_valid), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            set_data(5, 8'(b5)); last[5] = (b5 == 19);
            #1;
            chk("bst_a_sel", 32'(sel), 32'd5);
            chk("bst_a_ack", 32'(ack), 32'h0020);
            chk("bst_a_data", 32'(o_data), 32'(b5));
            tick(); b5++;
        end
        #1;
        chk("bst_bub1_valid", 32'(o_valid), 32'd0);
        chk("bst_bub1_ack", 32'(ack), 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_data(9, 8'(8'h90 + b9)); last[9] = (b9 == 1);
            #1;
            chk("bst_b_sel", 32'(sel), 32'd9);
            chk("bst_b_ack", 32'(ack), 32'h0200);
            chk("bst_b_data", 32'(o_data), 32'(8'h90 + b9));
            chk("bst_b_last", 32'(o_last), 32'(b9 == 1));
            tick(); b9++;
        end
        req[9] = 1'b0; last[9] = 1'b0;
        #1 chk("bst_bub2_valid", 32'(o_valid), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_data(5, 8'(b5)); last[5] = (b5 == 19);
            #1;
            chk("bst_c_sel", 32'(sel), 32'd5);
            chk("bst_c_ack", 32'(ack), 32'h0020);
            chk("bst_c_data", 32'(o_data), 32'(b5));
            tick(); b5++;
        end
        req = '0; last = '0;
        R = 1'b1; tick(); R = 1'b0;

        // Backpressure then withdrawal
        req = 16'h0004; o_ready = 1'b0;
        #1 chk("bp_idle_valid", 32'(o_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_sel", 32'(sel), 32'd2);
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_ack", 32'(ack), 32'd0);
            tick();
        end
        req = '0;
        #1;
        chk("wd_valid", 32'(o_valid), 32'd0);
        chk("wd_ack", 32'(ack), 32'd0);
        tick();
        // ptr must be 3: with 1 and 3 requesting, 3 wins
        req = 16'h000A;
        #1 chk("ptr3_idle_valid", 32'(o_valid), 32'd0);
        tick();
        #1;
        chk("ptr3_sel", 32'(sel), 32'd3);
        chk("ptr3_ack", 32'(ack), 32'd0);
        req = 16'h0010; o_ready = 1'b1; set_data(4, 8'h41);
        #1 chk("ptr3_wd_valid", 32'(o_valid), 32'd0);
        tick();
        #1 chk("rst_pkt_idle", 32'(o_valid), 32'd0);
        tick();

        // Reset mid-packet
        #1;
        chk("rstp_b1_sel", 32'(sel), 32'd4);
        chk("rstp_b1_ack", 32'(ack), 32'h0010);
        chk("rstp_b1_data", 32'(o_data), 32'h41);
        tick();
        set_data(4, 8'h42); R = 1'b1;
        #1;
        chk("rstp_b2_ack", 32'(ack), 32'd0);
        chk("rstp_b2_valid", 32'(o_valid), 32'd0);
        tick();
        R = 1'b0; req = 16'h0014;
        #1;
        chk("rstp_after_sel", 32'(sel), 32'd0);
        chk("rstp_after_valid", 32'(o_valid), 32'd0);
        chk("rstp_after_ack", 32'(ack), 32'd0);
        tick();
        #1;
        chk("rstp_regrant_sel", 32'(sel), 32'd2);
        chk("rstp_regrant_valid", 32'(o_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_tree_sched.md
# mux_tree_sched

Round-robin packet scheduler that shares one output channel among up to 16 requesters. The output data path is a 16:1 slice mux tree built from LUT6, MUXF7 and MUXF8 primitives. The block arbitrates between requesters and holds a grant for a whole packet or a bounded burst. It drives the registered 4-bit select of the mux tree and returns per-requester beat acknowledges. It sits between the per-source staging registers and a single downstream valid/ready consumer.

## Interface
- `N_REQ`, default 16: number of requesters, legal range 2..16. Unused select codes never occur.
- `DATA_W`, default 8: payload width; one mux tree per bit.
- `MAX_BURST`, default 8: maximum beats per grant before forced rotation, legal range 1..255.

Ports:
- `C` in 1: clock. All logic is on the rising edge.
- `R` in 1: reset. Synchronous, active-high.
- `req` in N_REQ: per-requester request. Held high while the requester has data.
- `last` in N_REQ: per-requester end-of-packet flag, qualified by `req`.
- `data_i` in N_REQ*DATA_W: payloads. Requester k occupies bits [k*DATA_W +: DATA_W].
- `ack` out N_REQ: one-hot. Bit k is high for the cycle in which requester k's beat is accepted.
- `sel` out 4: registered mux select, which is the current grantee index.
- `o_valid` out 1: output beat valid.
- `o_data` out DATA_W: equals the `data_i` slice selected by `sel`.
- `o_last` out 1: equals `last[sel]`, qualified by `o_valid`.
- `o_ready` in 1: downstream accept.

## Operation
- Two-state FSM, IDLE and GRANT.
- Registers:
  - `sel` (4 bits)
  - `ptr` (4 bits): round-robin start index
  - `cnt` (8 bits): beats in the current grant
- IDLE:
  - If any `req` bit is high, pick the first index k with `req[k]` high, scanning from `ptr` upward and wrapping from N_REQ-1 to 0.
  - Load `sel`<=k and `cnt`<=0, then go to GRANT.
  - With no request, stay in IDLE; `sel` holds its value.
- GRANT:
  - `o_valid = req[sel]`.
  - A transfer occurs when `o_valid & o_ready`. On a transfer, `ack[sel]`=1 in the same cycle and `cnt` increments.
  - Release to IDLE at the end of the cycle if any of these hold:
    - a transfer with `last[sel]`=1
    - a transfer that makes `cnt`==MAX_BURST
    - `req[sel]`=0 (requester withdrew; no transfer, no ack)
  - On release, `ptr`<=(`sel`+1), wrapping at N_REQ, and `cnt`<=0.
- Forced rotation at MAX_BURST does not wait for `last`. The interrupted requester re-competes and resumes its packet when granted again.
- Requests at indices other than `sel` are ignored during GRANT; they wait for the next IDLE.
- `o_data` and `o_last` are driven every cycle from the registered `sel`. Their value is don't-care when `o_valid`=0.
- `ack` bits other than `sel` are always 0. `ack` is never high in IDLE.

## Timing
- Reset values: state=IDLE, `sel`=0, `ptr`=0, `cnt`=0, `ack`=0, `o_valid`=0.
- `R` has priority over every other input. Asserting `R` mid-packet aborts the grant with no ack in that cycle. The requester's partial packet is its own responsibility.
- Arbitration latency: a request seen in IDLE at cycle t gives `o_valid` at t+1.
- After release there is exactly one IDLE bubble cycle before the next grant; no back-to-back grants.
- `o_valid`, `ack`, `o_data` and `o_last` are combinational from the registered `sel`/state and the current-cycle `req`/`last`/`data_i`/`o_ready`. The path is one mux tree deep (LUT6→MUXF7→MUXF8). There is no ready-to-ready loop inside the block.
- With a single active requester, it is re-granted after every release, with one bubble between grants.
- Steady-state throughput per grant is MAX_BURST beats per MAX_BURST+1 cycles when `o_ready`=1.

## Structure
- Package `mux_tree_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_GRANT`)
  - `SEL_W`=4
  - `CNT_W`=8
  - function `rr_pick(req, ptr, n)` returning the index and a found flag
- Sub-module `mux16_slice`: one bit of the 16:1 tree.
  - Four LUT6 configured as 4:1 muxes on `sel[1:0]`.
  - Two MUXF7 on `sel[2]`.
  - One MUXF8 on `sel[3]`, `O` output used.
  - Inputs at or above N_REQ are tied to 0.
- The top level instantiates DATA_W copies of `mux16_slice` for `o_data`, plus one for `o_last`.

## Test plan
- Reset, then `req`=0 for 10 cycles → `o_valid`=0, `ack`=0, `sel`=0 throughout.
- `req[3]`=1, 3-beat packet with `last` on beat 3, `o_ready`=1 → grant at t+1, `ack[3]` high on 3 consecutive cycles, `o_data` matches each beat, then IDLE, `ptr`=4.
- `req`=16'hFFFF, each requester sending 1-beat packets → grants in order 0,1,2,…,15,0 with one bubble between grants.
- `req[5]` with a 20-beat packet, MAX_BURST=8, `req[9]` also high → 8 beats of 5, bubble, 9's packet, bubble, 5 resumes.
- Granted `req[2]`, `o_ready`=0 for 4 cycles → `o_valid` held, no ack, `sel`=2 stable; then `req[2]` drops → release, no ack, `ptr`=3.
- `R` asserted during beat 2 of a 5-beat packet → next cycle all outputs are at reset values; after `R` deasserts, arbitration restarts from `ptr`=0.
